cmd_dispatcher: RTL

Parametrised command dispatcher between the UART receiver/transmitter pair and up to 16 worker modules (sampler, sample reader, test, …) that use an activate/done handshake. A received command byte selects one channel, which is activated and supervised until it reports done, is aborted, or times out. Every event is answered with a status byte over UART, and the current state is exported for the seven-segment display.

---
 rtl/cmd_dispatcher.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cmd_dispatcher.sv
// Command dispatcher: a UART command byte activates one worker channel, supervised until done/abort/timeout.
// Timeout supervision is present only when CMD_DISPATCHER_TIMEOUT_EN is defined.
module cmd_dispatcher #(
  parameter int         N_CH           = 4,
  parameter logic [7:0] CMD_BASE       = 8'h20,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic            clk_50mhz,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_ready,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  input  logic            tx_active,
  output logic [N_CH-1:0] activate,
  input  logic [N_CH-1:0] done,
  output logic [7:0]      state,
  output logic            busy
);
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;
  localparam logic [7:0] ABORT_CMD = 8'hFF;

  if (N_CH < 1 || N_CH > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("cmd_dispatcher: parameter out of range");
  end

  typedef enum logic {S_IDLE, S_RUN} fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [N_CH-1:0] act_q, act_d;
  logic [3:0]      ch_q, ch_d;
  logic [7:0]      state_q, state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      fifo_mem [4];

  logic       push, pop;
  logic [7:0] push_dat;
  logic [7:0] cmd_off;
  logic       cmd_valid, room, sel_done, timeout_hit;

  assign cmd_off   = rx_data - CMD_BASE;
  assign cmd_valid = (cmd_off < 8'(N_CH));
  // Occupancy limit of 3 keeps one slot free for the run's final report.
  assign room      = (cnt_q < 3'd3);
  assign sel_done  = |(done & act_q);
  assign pop       = (cnt_q != 3'd0) && !tx_active && !tx_start_q;

`ifdef CMD_DISPATCHER_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_q, to_d;

  assign timeout_hit = (fsm_q == S_RUN) && (to_q == TO_LAST);

  always_comb begin
    to_d = '0;
    if (fsm_q == S_RUN) to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    fsm_d    = fsm_q;
    act_d    = act_q;
    ch_d     = ch_q;
    state_d  = state_q;
    push     = 1'b0;
    push_dat = NAK;
    if (fsm_q == S_IDLE) begin
      if (rx_ready && room) begin
        push = 1'b1;
        if (cmd_valid) begin
          fsm_d    = S_RUN;
          ch_d     = cmd_off[3:0];
          act_d    = N_CH'(1) << cmd_off[3:0];
          state_d  = rx_data;
          push_dat = ACK;
        end
      end
    end else begin
      if (sel_done || (rx_ready && rx_data == ABORT_CMD) || timeout_hit) begin
        fsm_d   = S_IDLE;
        act_d   = '0;
        state_d = 8'h00;
        push    = 1'b1;
        if (sel_done)                              push_dat = {4'h8, ch_q};
        else if (rx_ready && rx_data == ABORT_CMD) push_dat = {4'hA, ch_q};
        else                                       push_dat = {4'hE, ch_q};
      end else if (rx_ready && room) begin
        push = 1'b1;
      end
    end
  end

  always_comb begin
    tx_start_d = pop;
    tx_data_d  = pop ? fifo_mem[rd_ptr_q] : tx_data_q;
    wr_ptr_d   = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
    cnt_d      = cnt_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk_50mhz) begin
    if (push) fifo_mem[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      fsm_q      <= S_IDLE;
      act_q      <= '0;
      ch_q       <= 4'd0;
      state_q    <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      cnt_q      <= 3'd0;
    end else begin
      fsm_q      <= fsm_d;
      act_q      <= act_d;
      ch_q       <= ch_d;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign activate = act_q;
  assign state    = state_q;
  assign busy     = (fsm_q == S_RUN);
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
endmodule
